// File: rtl/booth_seq_divider.sv
// ============================================================================
//  Module      : booth_seq_divider
//  Description : Sequential signed non-restoring divider, one quotient bit
//                per cycle, with a start/busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             divByZero
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIX    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]     r_p;
    logic [WIDTH:0]     r_vmag;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_dvd;
    logic               r_sign_d;
    logic               r_sign_q;
    logic               r_zero;
    logic [WIDTH-1:0]   r_quot_res;
    logic [WIDTH-1:0]   r_rem_res;

    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH:0]     w_dvs_ext;
    logic [WIDTH:0]     w_dvs_mag;
    logic [WIDTH:0]     w_p_shift;
    logic [WIDTH:0]     w_p_step;
    logic [WIDTH:0]     w_p_fix;
    logic [WIDTH-1:0]   w_q_res;
    logic [WIDTH-1:0]   w_r_res;

    // The dividend magnitude is kept as an unsigned WIDTH-bit value, which
    // represents 2^(WIDTH-1) exactly; the divisor needs the extra bit because
    // it takes part in signed (WIDTH+1)-bit arithmetic with the remainder.
    always_comb begin
        w_dvd_mag = Dividend[WIDTH-1] ? (~Dividend + 1'b1) : Dividend;
        w_dvs_ext = {Divisor[WIDTH-1], Divisor};
        w_dvs_mag = Divisor[WIDTH-1] ? (~w_dvs_ext + 1'b1) : w_dvs_ext;
        w_p_shift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
        w_p_step  = r_p[WIDTH] ? (w_p_shift + r_vmag) : (w_p_shift - r_vmag);
        w_p_fix   = r_p[WIDTH] ? (r_p + r_vmag) : r_p;
        w_q_res   = r_sign_q ? (~r_q + 1'b1) : r_q;
        w_r_res   = r_sign_d ? (~w_p_fix[WIDTH-1:0] + 1'b1) : w_p_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_p        <= '0;
            r_vmag     <= '0;
            r_q        <= '0;
            r_dvd      <= '0;
            r_sign_d   <= 1'b0;
            r_sign_q   <= 1'b0;
            r_zero     <= 1'b0;
            r_quot_res <= '0;
            r_rem_res  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            Quotient   <= '0;
            Remainder  <= '0;
            divByZero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q       <= w_dvd_mag;
                        r_vmag    <= w_dvs_mag;
                        r_dvd     <= Dividend;
                        r_sign_d  <= Dividend[WIDTH-1];
                        r_sign_q  <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                        r_zero    <= (Divisor == '0);
                        r_p       <= '0;
                        r_cnt     <= c_CNT_INIT;
                        busy      <= 1'b1;
                        divByZero <= 1'b0;
                        r_state   <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_p   <= w_p_step;
                    r_q   <= {r_q[WIDTH-2:0], ~w_p_step[WIDTH]};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_p <= w_p_fix;
                    // With a zero divisor every step subtracts nothing, so the
                    // raw quotient is all ones; the result is forced instead.
                    if (r_zero) begin
                        r_quot_res <= '1;
                        r_rem_res  <= r_dvd;
                    end else begin
                        r_quot_res <= w_q_res;
                        r_rem_res  <= w_r_res;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    Quotient  <= r_quot_res;
                    Remainder <= r_rem_res;
                    divByZero <= r_zero;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_divider.sv
// ============================================================================
//  Module      : tb_booth_seq_divider
//  Description : Self-checking bench for booth_seq_divider (WIDTH = 32).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_divider;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        busy;
    logic        done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        divByZero;

    int n_pass  = 0;
    int n_total = 0;

    booth_seq_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .busy      (busy),
        .done      (done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic (truncating division, remainder
    // takes the sign of the dividend), plus the divide-by-zero convention.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            z  = 1'b0;
        end
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        logic        hs_ok;
        model(a, b, eq, er, ez);
        @(negedge clk);
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        Dividend = $urandom;
        Divisor  = $urandom;
        hs_ok    = 1'b1;
        for (int j = 1; j <= 33; j++) begin
            @(posedge clk);
            #1;
            if (!(busy === 1'b1 && done === 1'b0)) hs_ok = 1'b0;
        end
        check({tag, "_busy_window"}, 64'(hs_ok), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_done"}, {busy, done}, 2'b01);
        check({tag, "_quot"}, Quotient, eq);
        check({tag, "_rem"}, Remainder, er);
        check({tag, "_dbz"}, divByZero, ez);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {done, Quotient}, {1'b0, eq});
    endtask

    initial begin
        logic [31:0] a1, b1, a2, b2, eq, er, rb;
        logic        ez, seen;
        int          n_done, d1, d2;

        resetN   = 1'b0;
        start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {busy, done, divByZero}, 3'b000);
        check("reset_quot", Quotient, 32'd0);
        check("reset_rem", Remainder, 32'd0);
        resetN = 1'b1;

        run_op("t1", 32'h1BB6BAA0, 32'h00000348);
        check("t1_const", Quotient, 32'h00087234);
        run_op("t2a", 32'hF7747564, 32'h00087234);
        run_op("t2b", 32'hF7747564, 32'hFFFFFEFD);
        run_op("neg7_2", 32'hFFFFFFF9, 32'd2);
        run_op("pos7_n2", 32'd7, 32'hFFFFFFFE);
        run_op("neg7_n2", 32'hFFFFFFF9, 32'hFFFFFFFE);
        run_op("5_7", 32'd5, 32'd7);
        run_op("div0", 32'd100, 32'd0);
        run_op("ovf", 32'h80000000, 32'hFFFFFFFF);
        run_op("mneg_1", 32'h80000000, 32'd1);
        run_op("zero_dvd", 32'd0, 32'h50647236);
        run_op("neg_div0", 32'hFFFFFF9C, 32'd0);

        for (int i = 0; i < 12; i++) begin
            a1 = $urandom;
            case (i % 3)
                0: b1 = $urandom;
                1: begin
                    rb = 32'($urandom_range(1, 1000));
                    b1 = $urandom_range(0, 1) ? (~rb + 1) : rb;
                end
                default: b1 = 32'($urandom_range(1, 65535));
            endcase
            if (i % 4 == 3) a1 = {{16{a1[15]}}, a1[15:0]};
            run_op("rand", a1, b1);
        end

        // Second start pulse mid-operation must be ignored.
        a1 = 32'hFFFF1234;
        b1 = 32'd77;
        model(a1, b1, eq, er, ez);
        @(negedge clk);
        Dividend = a1;
        Divisor  = b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        Dividend = 32'd12345;
        Divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (23) @(posedge clk);
        @(posedge clk);
        #1;
        check("ign_done", {busy, done}, 2'b01);
        check("ign_quot", Quotient, eq);
        check("ign_rem", Remainder, er);
        seen = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("ign_no_second", 64'(seen), 64'd0);

        // start held high: back-to-back operations 35 cycles apart.
        a1 = $urandom;
        b1 = 32'($urandom_range(1, 5000));
        a2 = $urandom;
        b2 = 32'hFFFFFFF3;
        n_done = 0;
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        Dividend = a1;
        Divisor  = b1;
        start    = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    d1 = i;
                    model(a1, b1, eq, er, ez);
                    check("hold_q1", {Quotient, Remainder}, {eq, er});
                    Dividend = a2;
                    Divisor  = b2;
                end else if (n_done == 2) begin
                    d2 = i;
                    model(a2, b2, eq, er, ez);
                    check("hold_q2", {Quotient, Remainder}, {eq, er});
                end
            end
        end
        start = 1'b0;
        check("hold_count", 64'(n_done), 64'd2);
        check("hold_first", 64'(d1), 64'd34);
        check("hold_gap", 64'(d2 - d1), 64'd35);
        repeat (40) @(posedge clk);

        // Reset in the middle of an operation aborts it silently.
        @(negedge clk);
        Dividend = 32'h7FFF0001;
        Divisor  = 32'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        resetN = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        check("rst_ctrl", {busy, done, divByZero}, 3'b000);
        check("rst_qr", {Quotient, Remainder}, 64'd0);
        seen = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        check("rst_no_done", 64'(seen), 64'd0);
        run_op("t1_again", 32'h1BB6BAA0, 32'h00000348);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/booth_seq_divider.md
Name: booth_seq_divider

Overview:
- Sequential signed integer divider: the inverse of the team's Booth multiplier datapath.
- Takes a signed dividend and divisor and produces a truncating quotient and remainder, one quotient bit per cycle (non-restoring).
- Sits beside the multiplier and uses a start/done handshake, so a bench can feed a multiplier product back in and recover the original operand.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (two's complement); must be >= 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetN  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- Dividend  input  WIDTH  signed dividend; captured on the accepted start.
- Divisor  input  WIDTH  signed divisor; captured on the accepted start.
- busy  output  1  high from the cycle after start is accepted until the cycle done rises.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- Quotient  output  WIDTH  signed quotient, truncated toward zero.
- Remainder  output  WIDTH  signed remainder; sign follows the dividend.
- divByZero  output  1  set with done when the captured divisor was 0; held until the next accepted start.

Behaviour:
- Reset: when resetN=0 at a rising edge:
  - state goes to IDLE;
  - busy=0, done=0, divByZero=0, Quotient=0, Remainder=0;
  - internal counter and accumulators are cleared;
  - this takes priority over everything, including mid-DIVIDE, and the aborted operation produces no done.
- States: IDLE, DIVIDE, FIX, DONE.
- IDLE, start=1 at edge k:
  - capture |Dividend|, |Divisor|, sign of dividend, and sign of the product (signD xor signV);
  - set the zero flag if Divisor==0;
  - counter=WIDTH-1; go to DIVIDE; busy=1 from cycle k+1.
- DIVIDE: one non-restoring step per cycle over a (WIDTH+1)-bit partial remainder P and a WIDTH-bit quotient register Q.
  - Shift {P,Q} left by 1.
  - If P was >=0, P=P-|V|; otherwise P=P+|V|.
  - Q[0] = ~P_new[WIDTH].
  - After WIDTH steps (counter reaches 0) go to FIX.
- FIX:
  - if P<0, P=P+|V|;
  - apply signs: Quotient = product-sign ? -Q : Q; Remainder = dividend-sign ? -P : P (truncated to WIDTH);
  - go to DONE.
- DONE: done=1 and busy=0 for exactly this cycle; outputs registered; return to IDLE. done therefore rises at edge k+WIDTH+2 (34 cycles for WIDTH=32).
- Outputs hold their values in IDLE until the next DONE or reset.
- Divide by zero: latency is unchanged. Result is Quotient = all ones (-1), Remainder = Dividend as captured, divByZero=1.
- Overflow (most-negative / -1): Quotient = most-negative value (wraps), Remainder = 0, divByZero=0. No flag.
- Dividend 0: Quotient=0, Remainder=0.
- start while busy or in DONE: ignored. Operands are not re-captured and nothing is queued.
- start held high continuously: a new operation is accepted in the IDLE cycle that follows DONE.
- Dividend/Divisor changing after capture has no effect on the operation in flight.
- Absolute value of the most-negative operand: computed in WIDTH+1 bits so that magnitude 2^(WIDTH-1) is exact.

Test Plan:
1. Dividend=0x1BB6BAA0, Divisor=0x00000348, pulse start -> done exactly 34 cycles after the start edge; Quotient=0x00087234, Remainder=0, divByZero=0, busy high for the 33 intervening cycles.
2. Dividend=0xF7747564, Divisor=0x00087234 -> Quotient=0xFFFFFEFD (-259), Remainder=0. Then Dividend=0xF7747564, Divisor=0xFFFFFEFD -> Quotient=0x00087234, Remainder=0.
3. Sign/remainder matrix:
   - -7/2 -> Q=0xFFFFFFFD, R=0xFFFFFFFF;
   - 7/-2 -> Q=0xFFFFFFFD, R=0x00000001;
   - -7/-2 -> Q=3, R=0xFFFFFFFF;
   - 5/7 -> Q=0, R=5.
4. Boundaries:
   - 100/0 -> Q=0xFFFFFFFF, R=100, divByZero=1, same 34-cycle latency;
   - 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0;
   - 0x80000000/1 -> Q=0x80000000, R=0;
   - 0/0x50647236 -> Q=0, R=0.
5. Handshake abuse: second start pulse with new operands 10 cycles into an operation -> ignored, first result unchanged. start held high for 80 cycles -> two back-to-back results, the second done 35 cycles after the first.
6. Reset: resetN=0 for one cycle at cycle 15 of an operation -> next edge busy=0, done never pulses, Q=R=0. A fresh start afterwards completes correctly (rerun case 1).
